boreal_ai_mailbox_nslot: RTL and testbench



---
 rtl/boreal_mailbox_pkg.sv | 21 ++
 rtl/boreal_mailbox_slot.sv | 91 +++++++++
 rtl/boreal_ai_mailbox_nslot.sv | 181 ++++++++++++++++++
 tb/tb_boreal_ai_mailbox_nslot.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_mailbox_pkg.sv
// Shared definitions for the N-slot AI mailbox: register map, slot state
// encoding, sequence-tag and overflow-counter widths.
package boreal_mailbox_pkg;

    localparam int unsigned SEQ_W = 8;
    localparam int unsigned OVF_W = 16;

    localparam logic [11:0] OFF_STATUS    = 12'h000;
    localparam logic [11:0] OFF_COMMIT    = 12'h004;
    localparam logic [11:0] OFF_SEQ_NEXT  = 12'h008;
    localparam logic [11:0] OFF_OVF_CNT   = 12'h00C;
    localparam logic [11:0] OFF_IRQ_MASK  = 12'h010;
    localparam logic [11:0] OFF_DATA_BASE = 12'h100;

    typedef enum logic [1:0] {
        SlotEmpty = 2'd0,
        SlotFill  = 2'd1,
        SlotReady = 2'd2
    } slot_state_e;

endpackage

// File: rtl/boreal_mailbox_slot.sv
// One mailbox slot: EMPTY/FILL/READY state, sequence tag and SLOT_WORDS of
// 32-bit storage with one MMIO read/write port and one VM read port.
module boreal_mailbox_slot
    import boreal_mailbox_pkg::*;
#(
    parameter int unsigned SLOT_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_we,
    input  logic [$clog2(SLOT_WORDS)-1:0] mmio_idx,
    input  logic [31:0]                   wdata,
    input  logic                          commit_req,
    input  logic                          vm_ack,
    input  logic [SEQ_W-1:0]              seq_in,
    input  logic [$clog2(SLOT_WORDS)-1:0] vm_idx,
    output logic                          ready,
    output logic                          data_drop,
    output logic                          commit_ok,
    output logic [SEQ_W-1:0]              tag,
    output logic [31:0]                   mmio_rdata,
    output logic [31:0]                   vm_rdata
);

    slot_state_e      state_q, state_d;
    logic [SEQ_W-1:0] tag_q;
    logic [31:0]      mem_q [SLOT_WORDS];
    logic             mem_we;

    // State and tag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SlotEmpty;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (commit_ok) begin
                tag_q <= seq_in;
            end
        end
    end

    // Next state; in READY a same-cycle ack wins and the commit is refused
    always_comb begin
        state_d   = state_q;
        data_drop = 1'b0;
        commit_ok = 1'b0;
        unique case (state_q)
            SlotEmpty: begin
                if (commit_req) begin
                    state_d   = SlotReady;
                    commit_ok = 1'b1;
                end else if (data_we) begin
                    state_d = SlotFill;
                end
            end
            SlotFill: begin
                if (commit_req) begin
                    state_d   = SlotReady;
                    commit_ok = 1'b1;
                end
            end
            SlotReady: begin
                data_drop = data_we;
                if (vm_ack) begin
                    state_d = SlotEmpty;
                end
            end
            default: state_d = SlotEmpty;
        endcase
    end

    assign mem_we = data_we && (state_q != SlotReady);

    // Slot storage; contents survive release so the VM can still read them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SLOT_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mmio_idx] <= wdata;
        end
    end

    assign ready      = (state_q == SlotReady);
    assign tag        = tag_q;
    assign mmio_rdata = mem_q[mmio_idx];
    assign vm_rdata   = mem_q[vm_idx];

endmodule

// File: rtl/boreal_ai_mailbox_nslot.sv
// N-slot AI mailbox: MMIO producer side with STATUS/COMMIT/SEQ_NEXT/OVF_CNT/
// IRQ_MASK registers and slot data window at 0x100, VM consumer side with
// direct combinational reads and per-slot release pulses.
// Optional feature macro: BOREAL_AI_MAILBOX_IRQ_EN (registered masked irq).
module boreal_ai_mailbox_nslot
    import boreal_mailbox_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SLOT_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel,
    input  logic                          wr,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata,
    output logic                          ack,
    input  logic [$clog2(NUM_SLOTS)-1:0]  vm_rd_slot,
    input  logic [$clog2(SLOT_WORDS)-1:0] vm_rd_idx,
    output logic [31:0]                   vm_rd_data,
    output logic [NUM_SLOTS-1:0]          vm_slot_valid,
    input  logic [NUM_SLOTS-1:0]          vm_slot_ack,
    output logic [8*NUM_SLOTS-1:0]        vm_slot_seq,
    output logic                          irq
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned WORD_W = $clog2(SLOT_WORDS);

    logic [11:0]        reg_off;
    logic [11:0]        data_off;
    logic [11:0]        data_slot_full;
    logic               is_data;
    logic [SLOT_W-1:0]  data_slot;
    logic [WORD_W-1:0]  data_word;
    logic               mmio_wr;
    logic               mmio_rd;
    logic               commit_wr;
    logic               commit_in_range;
    logic               ovf_event;
    logic               ovf_clear;
    logic [31:0]        rd_mux;

    logic [NUM_SLOTS-1:0] slot_we;
    logic [NUM_SLOTS-1:0] commit_req;
    logic [NUM_SLOTS-1:0] commit_ok;
    logic [NUM_SLOTS-1:0] slot_ready;
    logic [NUM_SLOTS-1:0] slot_drop;
    logic [NUM_SLOTS-1:0] irq_mask;
    logic [31:0]          mmio_word [NUM_SLOTS];
    logic [31:0]          vm_word   [NUM_SLOTS];

    logic                 ack_q;
    logic [31:0]          rdata_q;
    logic [SEQ_W-1:0]     seq_next_q;
    logic [OVF_W-1:0]     ovf_cnt_q;

    logic unused_addr;
    assign unused_addr = ^addr[31:12];

    assign reg_off         = addr[11:0];
    assign data_off        = reg_off - OFF_DATA_BASE;
    assign data_slot_full  = data_off >> (WORD_W + 2);
    assign is_data         = (reg_off >= OFF_DATA_BASE) && (data_slot_full < 12'(NUM_SLOTS));
    assign data_slot       = data_slot_full[SLOT_W-1:0];
    assign data_word       = data_off[WORD_W+1:2];
    assign mmio_wr         = sel && wr;
    assign mmio_rd         = sel && !wr;
    assign commit_wr       = mmio_wr && (reg_off == OFF_COMMIT);
    assign commit_in_range = (wdata < 32'(NUM_SLOTS));
    assign ovf_clear       = mmio_wr && (reg_off == OFF_OVF_CNT);
    // Dropped data write, or a commit that no slot accepted
    assign ovf_event       = (|slot_drop) || (commit_wr && !(|commit_ok));

    for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_slot
        assign slot_we[g]    = mmio_wr && is_data && (data_slot == SLOT_W'(g));
        assign commit_req[g] = commit_wr && commit_in_range && (wdata[SLOT_W-1:0] == SLOT_W'(g));

        boreal_mailbox_slot #(
            .SLOT_WORDS (SLOT_WORDS)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .data_we    (slot_we[g]),
            .mmio_idx   (data_word),
            .wdata      (wdata),
            .commit_req (commit_req[g]),
            .vm_ack     (vm_slot_ack[g]),
            .seq_in     (seq_next_q),
            .vm_idx     (vm_rd_idx),
            .ready      (slot_ready[g]),
            .data_drop  (slot_drop[g]),
            .commit_ok  (commit_ok[g]),
            .tag        (vm_slot_seq[8*g +: 8]),
            .mmio_rdata (mmio_word[g]),
            .vm_rdata   (vm_word[g])
        );
    end

    assign vm_slot_valid = slot_ready;

    // VM direct read mux; out-of-range slot reads return 0
    always_comb begin
        vm_rd_data = '0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            if (vm_rd_slot == SLOT_W'(s)) begin
                vm_rd_data = vm_word[s];
            end
        end
    end

    // MMIO read mux; unmapped offsets read 0
    always_comb begin
        rd_mux = '0;
        if (is_data) begin
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                if (data_slot == SLOT_W'(s)) begin
                    rd_mux = mmio_word[s];
                end
            end
        end else begin
            case (reg_off)
                OFF_STATUS:   rd_mux = 32'(slot_ready);
                OFF_SEQ_NEXT: rd_mux = 32'(seq_next_q);
                OFF_OVF_CNT:  rd_mux = 32'(ovf_cnt_q);
                OFF_IRQ_MASK: rd_mux = 32'(irq_mask);
                default:      rd_mux = '0;
            endcase
        end
    end

    // MMIO response, sequence counter and saturating overflow counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            seq_next_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            ack_q   <= sel;
            rdata_q <= mmio_rd ? rd_mux : '0;
            if (|commit_ok) begin
                seq_next_q <= seq_next_q + 1'b1;
            end
            if (ovf_clear) begin
                ovf_cnt_q <= '0;
            end else if (ovf_event && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;

`ifdef BOREAL_AI_MAILBOX_IRQ_EN
    logic [NUM_SLOTS-1:0] irq_mask_q;
    logic                 irq_q;

    // Interrupt mask and registered level interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (mmio_wr && (reg_off == OFF_IRQ_MASK)) begin
                irq_mask_q <= wdata[NUM_SLOTS-1:0];
            end
            irq_q <= |(slot_ready & irq_mask_q);
        end
    end

    assign irq_mask = irq_mask_q;
    assign irq      = irq_q;
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_boreal_ai_mailbox_nslot.sv
// Directed self-checking bench for boreal_ai_mailbox_nslot (4 slots x 16 words).
// Honours BOREAL_AI_MAILBOX_IRQ_EN for the interrupt scenario.
module tb_boreal_ai_mailbox_nslot;

    localparam int unsigned NUM_SLOTS  = 4;
    localparam int unsigned SLOT_WORDS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic [1:0]  vm_rd_slot = '0;
    logic [3:0]  vm_rd_idx = '0;
    logic [31:0] vm_rd_data;
    logic [3:0]  vm_slot_valid;
    logic [3:0]  vm_slot_ack = '0;
    logic [31:0] vm_slot_seq;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_v;
    logic        ack_v;

    boreal_ai_mailbox_nslot #(
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_WORDS (SLOT_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel           (sel),
        .wr            (wr),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .ack           (ack),
        .vm_rd_slot    (vm_rd_slot),
        .vm_rd_idx     (vm_rd_idx),
        .vm_rd_data    (vm_rd_data),
        .vm_slot_valid (vm_slot_valid),
        .vm_slot_ack   (vm_slot_ack),
        .vm_slot_seq   (vm_slot_seq),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d, output logic k);
        @(posedge clk); #1;
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0;
        k = ack;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d, output logic k);
        @(posedge clk); #1;
        sel = 1'b1; wr = 1'b0; addr = a; wdata = '0;
        @(posedge clk); #1;
        sel = 1'b0;
        d = rdata;
        k = ack;
    endtask

    task automatic vm_release(input int s);
        @(posedge clk); #1;
        vm_slot_ack = 4'(1 << s);
        @(posedge clk); #1;
        vm_slot_ack = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ack !== 1'b0) begin $display("FAIL reset_ack: got %b expected 0", ack); fails++; end
        tests++;
        if (rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h expected 0", rdata); fails++; end
        tests++;
        if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", irq); fails++; end
        tests++;
        if (vm_slot_valid !== 4'h0) begin
            $display("FAIL reset_valid: got %h expected 0", vm_slot_valid); fails++;
        end
        tests++;
        if (vm_slot_seq !== 32'h0) begin
            $display("FAIL reset_seq: got %h expected 0", vm_slot_seq); fails++;
        end
        rst = 1'b0;
    endtask

    task automatic test_commit_basic();
        mmio_write(32'h18C, 32'hA5A5_0001, ack_v);
        tests++;
        if (ack_v !== 1'b1) begin $display("FAIL write_ack: got %b expected 1", ack_v); fails++; end
        mmio_write(32'h004, 32'd2, ack_v);
        mmio_read(32'h000, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h4) begin $display("FAIL status_commit2: got %h expected 4", rd_v); fails++; end
        tests++;
        if (ack_v !== 1'b1) begin $display("FAIL read_ack: got %b expected 1", ack_v); fails++; end
        tests++;
        if (vm_slot_seq[23:16] !== 8'h00) begin
            $display("FAIL seq_slot2: got %h expected 00", vm_slot_seq[23:16]); fails++;
        end
        vm_rd_slot = 2'd2; vm_rd_idx = 4'd3; #1;
        tests++;
        if (vm_rd_data !== 32'hA5A5_0001) begin
            $display("FAIL vm_rd_2_3: got %h expected a5a50001", vm_rd_data); fails++;
        end
        mmio_read(32'h18C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'hA5A5_0001) begin
            $display("FAIL mmio_rd_2_3: got %h expected a5a50001", rd_v); fails++;
        end
        mmio_read(32'h008, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h1) begin $display("FAIL seq_next_1: got %h expected 1", rd_v); fails++; end
    endtask

    task automatic test_overflow();
        mmio_write(32'h18C, 32'hDEAD_BEEF, ack_v);
        vm_rd_slot = 2'd2; vm_rd_idx = 4'd3; #1;
        tests++;
        if (vm_rd_data !== 32'hA5A5_0001) begin
            $display("FAIL ready_write_dropped: got %h expected a5a50001", vm_rd_data); fails++;
        end
        mmio_read(32'h00C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h1) begin $display("FAIL ovf_after_drop: got %h expected 1", rd_v); fails++; end
        mmio_write(32'h004, 32'd7, ack_v);
        mmio_read(32'h00C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h2) begin $display("FAIL ovf_commit7: got %h expected 2", rd_v); fails++; end
        mmio_write(32'h004, 32'd2, ack_v);
        mmio_read(32'h00C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h3) begin $display("FAIL ovf_commit_ready: got %h expected 3", rd_v); fails++; end
        mmio_write(32'h00C, 32'h0, ack_v);
        mmio_read(32'h00C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h0) begin $display("FAIL ovf_clear: got %h expected 0", rd_v); fails++; end
        vm_release(2);
        mmio_read(32'h000, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h0) begin $display("FAIL status_released: got %h expected 0", rd_v); fails++; end
        tests++;
        if (vm_rd_data !== 32'hA5A5_0001) begin
            $display("FAIL data_retained: got %h expected a5a50001", vm_rd_data); fails++;
        end
        // Ack on a non-READY slot must be ignored
        vm_release(3);
        tests++;
        if (vm_slot_valid !== 4'h0) begin
            $display("FAIL ack_empty_ignored: got %h expected 0", vm_slot_valid); fails++;
        end
    endtask

    task automatic test_collision();
        mmio_write(32'h100, 32'h0000_0011, ack_v);
        @(posedge clk); #1;
        sel = 1'b1; wr = 1'b1; addr = 32'h004; wdata = 32'd0; vm_slot_ack = 4'b0001;
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0; vm_slot_ack = '0;
        tests++;
        if (vm_slot_valid !== 4'b0001) begin
            $display("FAIL collide_fill_commit_wins: got %h expected 1", vm_slot_valid); fails++;
        end
        tests++;
        if (vm_slot_seq[7:0] !== 8'h01) begin
            $display("FAIL collide_tag0: got %h expected 01", vm_slot_seq[7:0]); fails++;
        end
        @(posedge clk); #1;
        sel = 1'b1; wr = 1'b1; addr = 32'h004; wdata = 32'd0; vm_slot_ack = 4'b0001;
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0; vm_slot_ack = '0;
        tests++;
        if (vm_slot_valid !== 4'b0000) begin
            $display("FAIL collide_ready_ack_wins: got %h expected 0", vm_slot_valid); fails++;
        end
        mmio_read(32'h00C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h1) begin $display("FAIL collide_ovf: got %h expected 1", rd_v); fails++; end
        mmio_read(32'h008, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h2) begin $display("FAIL collide_seq_next: got %h expected 2", rd_v); fails++; end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        sel = 1'b1; wr = 1'b0; addr = 32'h008;
        @(posedge clk); #1;
        addr = 32'h020;
        tests++;
        if (ack !== 1'b1 || rdata !== 32'h2) begin
            $display("FAIL b2b_first: got ack=%b data=%h expected ack=1 data=2", ack, rdata); fails++;
        end
        @(posedge clk); #1;
        addr = 32'h200;
        tests++;
        if (ack !== 1'b1 || rdata !== 32'h0) begin
            $display("FAIL b2b_unmapped: got ack=%b data=%h expected ack=1 data=0", ack, rdata);
            fails++;
        end
        @(posedge clk); #1;
        sel = 1'b0;
        tests++;
        if (ack !== 1'b1 || rdata !== 32'h0) begin
            $display("FAIL b2b_beyond_data: got ack=%b data=%h expected ack=1 data=0", ack, rdata);
            fails++;
        end
        @(posedge clk); #1;
        tests++;
        if (ack !== 1'b0) begin $display("FAIL b2b_ack_drop: got %b expected 0", ack); fails++; end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int i = 0; i < 257; i++) begin
            mmio_write(32'h004, 32'd1, ack_v);
            if (i != 256) vm_release(1);
        end
        tests++;
        if (vm_slot_seq[15:8] !== 8'h00) begin
            $display("FAIL wrap_last_tag: got %h expected 00", vm_slot_seq[15:8]); fails++;
        end
        mmio_read(32'h008, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h1) begin $display("FAIL wrap_seq_next: got %h expected 1", rd_v); fails++; end
        mmio_read(32'h00C, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h0) begin $display("FAIL wrap_no_ovf: got %h expected 0", rd_v); fails++; end
        vm_release(1);
    endtask

    task automatic test_irq();
        mmio_write(32'h010, 32'h2, ack_v);
        mmio_read(32'h010, rd_v, ack_v);
`ifdef BOREAL_AI_MAILBOX_IRQ_EN
        tests++;
        if (rd_v !== 32'h2) begin $display("FAIL irq_mask_rb: got %h expected 2", rd_v); fails++; end
        // Unmasked slot must not raise irq
        mmio_write(32'h004, 32'd0, ack_v);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b0) begin $display("FAIL irq_masked_slot: got %b expected 0", irq); fails++; end
        mmio_write(32'h004, 32'd1, ack_v);
        tests++;
        if (irq !== 1'b0) begin $display("FAIL irq_not_yet: got %b expected 0", irq); fails++; end
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b1) begin $display("FAIL irq_raised: got %b expected 1", irq); fails++; end
        vm_release(1);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b0) begin $display("FAIL irq_cleared: got %b expected 0", irq); fails++; end
`else
        tests++;
        if (rd_v !== 32'h0) begin $display("FAIL irq_mask_rb: got %h expected 0", rd_v); fails++; end
        mmio_write(32'h004, 32'd1, ack_v);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b0 || vm_slot_valid[1] !== 1'b1) begin
            $display("FAIL irq_disabled: got irq=%b valid1=%b expected irq=0 valid1=1",
                     irq, vm_slot_valid[1]);
            fails++;
        end
        vm_release(1);
        tests++;
        if (irq !== 1'b0) begin $display("FAIL irq_disabled_after: got %b expected 0", irq); fails++; end
`endif
    endtask

    task automatic test_reset_mid();
        mmio_write(32'h1C0, 32'h1234_5678, ack_v);
        mmio_write(32'h004, 32'd2, ack_v);
        @(posedge clk); #1;
        sel = 1'b1; wr = 1'b0; addr = 32'h000;
        rst = 1'b1;
        #1;
        tests++;
        if (ack !== 1'b0 || rdata !== 32'h0 || vm_slot_valid !== 4'h0 || irq !== 1'b0) begin
            $display("FAIL rst_mid_outputs: got ack=%b rdata=%h valid=%h irq=%b expected all 0",
                     ack, rdata, vm_slot_valid, irq);
            fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0; sel = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ack !== 1'b0) begin $display("FAIL rst_mid_no_ack: got %b expected 0", ack); fails++; end
        mmio_read(32'h000, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h0) begin $display("FAIL rst_mid_status: got %h expected 0", rd_v); fails++; end
        mmio_read(32'h1C0, rd_v, ack_v);
        tests++;
        if (rd_v !== 32'h0) begin $display("FAIL rst_mid_data: got %h expected 0", rd_v); fails++; end
        tests++;
        if (vm_slot_seq !== 32'h0) begin
            $display("FAIL rst_mid_tags: got %h expected 0", vm_slot_seq); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_commit_basic();
        test_overflow();
        test_collision();
        test_back_to_back();
        test_seq_wrap();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
